// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words over valid/ready and streams one bit per clock on x,
// chaining words back to back so patterns across a word boundary survive.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam int             OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             x_next;
  logic             x_valid_next;
  logic             at_last;
  logic             accept;

  // The shift register always holds the bit currently on x at OUT_IDX, so
  // advancing one bit means moving everything one place toward that end.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      shift_one = {v[WIDTH-2:0], 1'b0};
    else
      shift_one = {1'b0, v[WIDTH-1:1]};
  endfunction

  // Handshake decodes come from registered state only, never from din_valid.
  assign at_last   = (state == SHIFT) && (cnt == LAST);
  assign din_ready = (state == IDLE) || at_last;
  assign word_done = at_last;
  assign accept    = din_valid && din_ready;
  assign busy      = x_valid;

  // Next-state, datapath and next-output decode for the serialiser.
  always_comb begin
    state_next   = state;
    sreg_next    = sreg;
    cnt_next     = cnt;
    x_valid_next = 1'b0;
    x_next       = IDLE_BIT;
    if (accept) begin
      state_next = SHIFT;
      sreg_next  = din;
      cnt_next   = '0;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state_next = IDLE;
        sreg_next  = '0;
        cnt_next   = '0;
      end else begin
        sreg_next = shift_one(sreg);
        cnt_next  = cnt + CW'(1);
      end
    end
    x_valid_next = (state_next == SHIFT);
    if (x_valid_next)
      x_next = sreg_next[OUT_IDX];
  end

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      sreg <= sreg_next;
      cnt  <= cnt_next;
    end
  end

  // Registered serial outputs, so the first bit appears on the accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
    end else begin
      x       <= x_next;
      x_valid <= x_valid_next;
    end
  end

  a_done_in_word: assert property (@(posedge clk) disable iff (!reset_n)
    word_done |-> x_valid);

  a_idle_level: assert property (@(posedge clk) disable iff (!reset_n)
    !x_valid |-> (x == IDLE_BIT));

  a_valid_tracks_state: assert property (@(posedge clk) disable iff (!reset_n)
    x_valid == (state == SHIFT));

endmodule
